// File: rtl/mem_bist_master.sv
// Memory BIST initiator: writes a deterministic byte pattern over an address
// window through the mem_ctrl CPU-side port, reads it back, and reports the
// pass/fail result, the mismatch count and the first failing location.
module mem_bist_master #(
    parameter int unsigned        MADDR_L   = 32,
    parameter int unsigned        DATA_L    = 8,
    parameter logic [MADDR_L-1:0] BASE_ADDR = MADDR_L'(32'h0000_1000),
    parameter int unsigned        LEN       = 256,
    parameter int unsigned        RD_LAT    = 2,
    parameter logic [7:0]         SEED      = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DATA_L-1:0]  rdata,
    output logic [DATA_L-1:0]  wdata,
    output logic [MADDR_L-1:0] raddr,
    output logic [MADDR_L-1:0] waddr,
    output logic               re,
    output logic               we,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [MADDR_L-1:0] err_addr,
    output logic [DATA_L-1:0]  err_exp,
    output logic [DATA_L-1:0]  err_got
);

    localparam int unsigned       IDX_W    = 32;
    localparam int unsigned       CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LEN - 1);
    localparam logic [CNT_W-1:0]  LAT_LOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, WRITE, RD_ISSUE, RD_WAIT, CHECK, DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_L-1:0]    cap_q, cap_d;
    logic [DATA_L-1:0]    wdata_q, wdata_d;
    logic [MADDR_L-1:0]   raddr_q, raddr_d;
    logic [MADDR_L-1:0]   waddr_q, waddr_d;
    logic                 re_q, re_d;
    logic                 we_q, we_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic [15:0]          err_count_q, err_count_d;
    logic [MADDR_L-1:0]   err_addr_q, err_addr_d;
    logic [DATA_L-1:0]    err_exp_q, err_exp_d;
    logic [DATA_L-1:0]    err_got_q, err_got_d;
    logic                 mismatch;
    logic [15:0]          err_cnt_nxt;
    logic [IDX_W-1:0]     idx_inc;

    // Pattern byte: low address byte (only low index bits reach it) ^ seed ^ index[15:8].
    function automatic logic [DATA_L-1:0] pat(input logic [15:0] idx);
        logic [7:0] lo;
        lo  = 8'(BASE_ADDR[7:0] + idx[7:0]);
        pat = DATA_L'(lo ^ SEED ^ idx[15:8]);
    endfunction

    // State and registered outputs; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            wdata_q     <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            wdata_q     <= wdata_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            re_q        <= re_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
        end
    end

    // Next state; strobes are computed for the state being entered so they line up with it.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        wdata_d     = wdata_q;
        raddr_d     = raddr_q;
        waddr_d     = waddr_q;
        re_d        = 1'b0;
        we_d        = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        err_exp_d   = err_exp_q;
        err_got_d   = err_got_q;
        idx_inc     = idx_q + IDX_W'(1);
        mismatch    = (cap_q != pat(idx_q[15:0]));
        err_cnt_nxt = err_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_count_d = '0;
                    err_addr_d  = '0;
                    err_exp_d   = '0;
                    err_got_d   = '0;
                    pass_d      = 1'b0;
                    idx_d       = '0;
                    if (LEN == 0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = WRITE;
                        busy_d  = 1'b1;
                        we_d    = 1'b1;
                        waddr_d = BASE_ADDR;
                        wdata_d = pat(16'd0);
                    end
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = RD_ISSUE;
                    re_d    = 1'b1;
                    raddr_d = BASE_ADDR;
                end else begin
                    idx_d   = idx_inc;
                    we_d    = 1'b1;
                    waddr_d = BASE_ADDR + MADDR_L'(idx_inc);
                    wdata_d = pat(idx_inc[15:0]);
                end
            end
            RD_ISSUE: begin
                cnt_d   = LAT_LOAD;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    cap_d   = rdata;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_count_q != 16'hFFFF) begin
                        err_cnt_nxt = err_count_q + 16'd1;
                    end
                    if (err_count_q == 16'd0) begin
                        err_addr_d = BASE_ADDR + MADDR_L'(idx_q);
                        err_exp_d  = pat(idx_q[15:0]);
                        err_got_d  = cap_q;
                    end
                end
                err_count_d = err_cnt_nxt;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_cnt_nxt == 16'd0);
                end else begin
                    idx_d   = idx_inc;
                    state_d = RD_ISSUE;
                    re_d    = 1'b1;
                    raddr_d = BASE_ADDR + MADDR_L'(idx_inc);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wdata     = wdata_q;
    assign raddr     = raddr_q;
    assign waddr     = waddr_q;
    assign re        = re_q;
    assign we        = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;
    assign err_exp   = err_exp_q;
    assign err_got   = err_got_q;

endmodule

// File: tb/tb_mem_bist_master.sv
// Bench for mem_bist_master: a RAM model with fault modes behind one instance
// (LEN=4) and a LEN=0 instance; expected writes/results are queued at start.
module tb_mem_bist_master;

    localparam int unsigned RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_b = 1'b0;

    logic [7:0]  a_rdata, a_wdata, a_err_exp, a_err_got;
    logic [31:0] a_raddr, a_waddr, a_err_addr;
    logic        a_re, a_we, a_busy, a_done, a_pass;
    logic [15:0] a_err_count;

    logic [7:0]  b_rdata = 8'h00;
    logic [7:0]  b_wdata, b_err_exp, b_err_got;
    logic [31:0] b_raddr, b_waddr, b_err_addr;
    logic        b_re, b_we, b_busy, b_done, b_pass;
    logic [15:0] b_err_count;

    always #5 clk = ~clk;

    mem_bist_master #(
        .MADDR_L(32), .DATA_L(8), .BASE_ADDR(32'h0000_1000),
        .LEN(4), .RD_LAT(RD_LAT), .SEED(8'hA5)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .rdata(a_rdata),
        .wdata(a_wdata), .raddr(a_raddr), .waddr(a_waddr),
        .re(a_re), .we(a_we), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_count(a_err_count), .err_addr(a_err_addr),
        .err_exp(a_err_exp), .err_got(a_err_got)
    );

    mem_bist_master #(
        .MADDR_L(32), .DATA_L(8), .BASE_ADDR(32'h0000_1000),
        .LEN(0), .RD_LAT(RD_LAT), .SEED(8'hA5)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rdata(b_rdata),
        .wdata(b_wdata), .raddr(b_raddr), .waddr(b_waddr),
        .re(b_re), .we(b_we), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_count(b_err_count), .err_addr(b_err_addr),
        .err_exp(b_err_exp), .err_got(b_err_got)
    );

    // Cycle index: after the rising edge that opens cycle N, cyc == N.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: 0 = good, 1 = byte at 0x1002 reads as 0x00, 2 = all reads 0xFF.
    int          mode = 0;
    logic [7:0]  mem [256];
    logic [7:0]  pipe [RD_LAT];

    function automatic logic [7:0] mem_read(input logic [31:0] a);
        if (mode == 2) return 8'hFF;
        if (mode == 1 && a == 32'h0000_1002) return 8'h00;
        return mem[a[7:0]];
    endfunction

    always @(posedge clk) begin
        if (a_we) mem[a_waddr[7:0]] <= a_wdata;
        pipe[0] <= mem_read(a_raddr);
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign a_rdata = pipe[RD_LAT-1];

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        pass;
        logic [15:0] cnt;
        logic [31:0] addr;
        logic [7:0]  exp;
        logic [7:0]  got;
    } res_t;

    wr_t         wr_q[$];
    res_t        res_q[$];
    logic [31:0] res_b_q[$];

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;
    int b_act = 0;

    logic [7:0] pat_tab [4] = '{8'hA5, 8'hA4, 8'hA7, 8'hA6};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag, input logic [4:0] ctl, input logic [15:0] cnt,
                              input logic [31:0] ea, input logic [7:0] ee, input logic [7:0] eg,
                              input logic [7:0] wd, input logic [31:0] wa, input logic [31:0] ra);
        check({tag, "_ctl"},       64'(ctl), 64'd0);
        check({tag, "_err_count"}, 64'(cnt), 64'd0);
        check({tag, "_err_addr"},  64'(ea),  64'd0);
        check({tag, "_err_bytes"}, 64'({ee, eg}), 64'd0);
        check({tag, "_wdata"},     64'(wd),  64'd0);
        check({tag, "_waddr"},     64'(wa),  64'd0);
        check({tag, "_raddr"},     64'(ra),  64'd0);
    endtask

    // Queue the four writes of a LEN=4 run started in cycle s, and optionally its result.
    task automatic push_run(input logic [31:0] s, input bit with_res, input logic p,
                            input logic [15:0] cnt, input logic [31:0] ea,
                            input logic [7:0] ee, input logic [7:0] eg);
        wr_t  w;
        res_t r;
        for (int k = 0; k < 4; k++) begin
            w.cyc  = s + 32'(k) + 32'd1;
            w.addr = 32'h0000_1000 + 32'(k);
            w.data = pat_tab[k];
            wr_q.push_back(w);
        end
        if (with_res) begin
            r.cyc = s + 32'd21; r.pass = p; r.cnt = cnt;
            r.addr = ea; r.exp = ee; r.got = eg;
            res_q.push_back(r);
        end
    endtask

    task automatic pulse_run(input logic p, input logic [15:0] cnt, input logic [31:0] ea,
                             input logic [7:0] ee, input logic [7:0] eg);
        @(negedge clk);
        start = 1'b1;
        push_run(cyc, 1'b1, p, cnt, ea, ee, eg);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((wr_q.size() != 0 || res_q.size() != 0 || res_b_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 64'(wr_q.size() + res_q.size() + res_b_q.size()), 64'd0);
        wr_q.delete();
        res_q.delete();
        res_b_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Monitor: pops expected writes/results whenever the DUTs present them.
    wr_t         mon_w;
    res_t        mon_r;
    logic [31:0] mon_bc;
    always @(negedge clk) begin
        if (!rst) begin
            if (a_re && a_we) overlap_cnt++;
            if (b_re || b_we) b_act++;
            if (a_we) begin
                check("write_expected", 64'(wr_q.size() != 0), 64'd1);
                if (wr_q.size() != 0) begin
                    mon_w = wr_q.pop_front();
                    check("write_cycle", 64'(cyc), 64'(mon_w.cyc));
                    check("write_addr",  64'(a_waddr), 64'(mon_w.addr));
                    check("write_data",  64'(a_wdata), 64'(mon_w.data));
                end
            end
            if (a_done) begin
                check("done_expected", 64'(res_q.size() != 0), 64'd1);
                if (res_q.size() != 0) begin
                    mon_r = res_q.pop_front();
                    check("done_cycle",   64'(cyc), 64'(mon_r.cyc));
                    check("pass",         64'(a_pass), 64'(mon_r.pass));
                    check("err_count",    64'(a_err_count), 64'(mon_r.cnt));
                    check("err_addr",     64'(a_err_addr), 64'(mon_r.addr));
                    check("err_exp",      64'(a_err_exp), 64'(mon_r.exp));
                    check("err_got",      64'(a_err_got), 64'(mon_r.got));
                    check("busy_at_done", 64'(a_busy), 64'd0);
                end
            end
            if (b_done) begin
                check("len0_done_expected", 64'(res_b_q.size() != 0), 64'd1);
                if (res_b_q.size() != 0) begin
                    mon_bc = res_b_q.pop_front();
                    check("len0_done_cycle", 64'(cyc), 64'(mon_bc));
                    check("len0_pass", 64'(b_pass), 64'd1);
                    check("len0_err_count", 64'(b_err_count), 64'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int nd;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        for (int k = 0; k < int'(RD_LAT); k++) pipe[k] = 8'h00;

        // Reset state of both instances.
        repeat (3) @(negedge clk);
        check_zero("rst_a", {a_we, a_re, a_busy, a_done, a_pass}, a_err_count, a_err_addr,
                   a_err_exp, a_err_got, a_wdata, a_waddr, a_raddr);
        check_zero("rst_b", {b_we, b_re, b_busy, b_done, b_pass}, b_err_count, b_err_addr,
                   b_err_exp, b_err_got, b_wdata, b_waddr, b_raddr);
        rst = 1'b0;

        // Good memory.
        mode = 0;
        pulse_run(1'b1, 16'd0, 32'h0, 8'h00, 8'h00);
        wait_drain(60);

        // Stuck byte at 0x1002.
        mode = 1;
        pulse_run(1'b0, 16'd1, 32'h0000_1002, 8'hA7, 8'h00);
        wait_drain(60);

        // Every read returns 0xFF: only the first mismatch is captured.
        mode = 2;
        pulse_run(1'b0, 16'd4, 32'h0000_1000, 8'hA5, 8'hFF);
        wait_drain(60);

        // LEN=0 instance: done one cycle after start, no traffic.
        @(negedge clk);
        start_b = 1'b1;
        res_b_q.push_back(cyc + 32'd1);
        @(negedge clk);
        start_b = 1'b0;
        wait_drain(20);
        check("len0_pass_held", 64'(b_pass), 64'd1);

        // Reset while waiting on a read.
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        push_run(s, 1'b0, 1'b0, 16'd0, 32'h0, 8'h00, 8'h00);
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 32'd6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_zero("midrst", {a_we, a_re, a_busy, a_done, a_pass}, a_err_count, a_err_addr,
                   a_err_exp, a_err_got, a_wdata, a_waddr, a_raddr);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (a_done) nd++;
        end
        check("no_done_after_rst", 64'(nd), 64'd0);
        check("writes_before_rst", 64'(wr_q.size()), 64'd0);
        pulse_run(1'b1, 16'd0, 32'h0, 8'h00, 8'h00);
        wait_drain(60);

        // start held high: failing run, then a clean restart right after DONE.
        mode = 2;
        @(negedge clk);
        start = 1'b1;
        s = cyc;
        push_run(s, 1'b1, 1'b0, 16'd4, 32'h0000_1000, 8'hA5, 8'hFF);
        push_run(s + 32'd22, 1'b1, 1'b1, 16'd0, 32'h0, 8'h00, 8'h00);
        while (cyc < s + 32'd22) @(negedge clk);
        mode = 0;
        while (cyc < s + 32'd30) @(negedge clk);
        start = 1'b0;
        wait_drain(80);
        check("pass_held_idle", 64'(a_pass), 64'd1);

        check("re_we_exclusive", 64'(overlap_cnt), 64'd0);
        check("len0_no_rw", 64'(b_act), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bist_master.md
Name: mem_bist_master

Overview:
- Built-in self-test initiator that drives the CPU-side byte interface of mem_ctrl in place of riscv_cpu.
- Writes a deterministic byte pattern over an address window, then reads it back and compares it.
- Reports pass/fail, the error count and the first failing address, so RAM and mem_ctrl can be qualified without running CPU firmware.
- Sits between the test harness (start/status) and mem_ctrl (c_din/c_dout/c_raddr/c_waddr/c_re/c_we).

Parameters:
- MADDR_L, 32, address width.
- DATA_L, 8, data width; must match the mem_ctrl CPU-side data width.
- BASE_ADDR, 32'h0000_1000, first address of the test window.
- LEN, 256, number of bytes tested; 0 is legal.
- RD_LAT, 2, read latency in cycles from re to valid data; must be at least 1.
- SEED, 8'hA5, pattern XOR constant.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  level-sampled start request.
- rdata  in  DATA_L  read data from mem_ctrl.
- wdata  out  DATA_L  write data to mem_ctrl.
- raddr  out  MADDR_L  read address.
- waddr  out  MADDR_L  write address.
- re  out  1  read enable, high for exactly one cycle per read.
- we  out  1  write enable, high for one cycle per byte.
- busy  out  1  test in progress.
- done  out  1  one-cycle completion pulse.
- pass  out  1  result of the last completed test; held until the next start.
- err_count  out  16  number of mismatches; saturates at 16'hFFFF.
- err_addr  out  MADDR_L  address of the first mismatch.
- err_exp  out  DATA_L  expected byte at the first mismatch.
- err_got  out  DATA_L  received byte at the first mismatch.

Behaviour:
- Reset values: clk and rst as given; every output is 0; the FSM is in IDLE; the index i is 0.
- rst is sampled on each clock edge and overrides everything, including mid-test. re and we are low from the first edge with rst high, and no done pulse follows.
- Pattern: pat(i) = (BASE_ADDR+i)[7:0] XOR SEED XOR i[15:8], for i = 0..LEN-1. Addresses are MADDR_L-bit modulo and wrap silently.
- FSM states: IDLE, WRITE, RD_ISSUE, RD_WAIT, CHECK, DONE.
- IDLE:
  - start=1 with LEN>0: clear err_count, err_addr, err_exp, err_got and pass; set i=0 and busy=1; go to WRITE.
  - start=1 with LEN=0: go directly to DONE.
- WRITE: each cycle drive we=1, waddr=BASE_ADDR+i, wdata=pat(i), then increment i. After the write with i=LEN-1, set i=0 and go to RD_ISSUE. Writes are back-to-back, one per cycle, with no gaps.
- RD_ISSUE: one cycle with re=1 and raddr=BASE_ADDR+i; load the latency counter with RD_LAT-1; go to RD_WAIT. raddr holds its value until the next RD_ISSUE.
- RD_WAIT: decrement the counter. When it reaches 0, register rdata at the edge that ends the cycle RD_LAT after the re cycle, and go to CHECK.
- CHECK: compare the captured byte with pat(i).
  - On mismatch, increment err_count (saturating).
  - If this is the first mismatch (err_count was 0), also load err_addr, err_exp and err_got.
  - If i=LEN-1, go to DONE; otherwise increment i and go to RD_ISSUE.
- Per-read cost is RD_LAT+2 cycles. Only one read is outstanding at a time.
- DONE: one cycle with done=1 and busy=0; pass=(err_count==0), held until the next start; then go to IDLE.
- The error fields hold their values after DONE until the next start.
- start is ignored while busy=1.
- Latency: if start is sampled at cycle 0, done is high in cycle LEN*(RD_LAT+3)+1 (LEN writes, plus LEN*(RD_LAT+2) read cycles, plus 1).
- For LEN=0, done is high in cycle 1 with pass=1 and no re/we activity.
- re and we are never high in the same cycle.

Test Plan:
- Good memory, LEN=4, RD_LAT=2, BASE=0x1000, SEED=0xA5 -> writes 0xA5,0xA4,0xA7,0xA6 to 0x1000..0x1003 on consecutive cycles; done in cycle 21; pass=1; err_count=0.
- Stuck-at model forcing rdata=0x00 on a read of 0x1002 -> err_count=1, err_addr=0x1002, err_exp=0xA7, err_got=0x00, pass=0.
- Every read returns 0xFF, LEN=4 -> err_count=4; the error fields capture the first mismatch only (0x1000, exp 0xA5, got 0xFF).
- LEN=0 -> done pulse in cycle 1, pass=1, re and we never asserted.
- rst asserted while in RD_WAIT -> all outputs 0 on the next edge, no done pulse. A later start reruns the full test and passes.
- start held high for the whole test -> exactly one test runs; a second test starts in the cycle after DONE, and the error fields are cleared at that restart.
